tilt_ctrl: RTL and testbench

- Consumes the averaged signed 16-bit x/y tilt values and the `ready` flag from the accelerometer front end. Turns them into calibrated, dead-zoned direction commands for game/control logic.
- Runs on the system clock. Samples the slow-domain averages with a tear-free double-capture.
- Zero-offset calibration is taken from the first 2^CAL_LOG2 samples after `ready`. Output is per-axis direction plus auto-repeating step pulses.

---
 rtl/tilt_pkg.sv | 29 ++
 rtl/tilt_axis.sv | 69 ++++++
 rtl/tilt_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_tilt_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tilt_pkg.sv
// Shared encodings and helpers for the tilt controller.
package tilt_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_POS  = 2'b01,
        DIR_NEG  = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        CAL        = 2'd1,
        RUN        = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SMP_IDLE = 2'd0,
        SMP_CAPB = 2'd1,
        SMP_CMP  = 2'd2
    } smp_t;

    function automatic logic [15:0] sat17to16(input logic [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'h8000 : 16'h7fff;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/tilt_axis.sv
// One tilt axis: offset correction with saturation and a hysteretic dead-zone
// direction register.
module tilt_axis
    import tilt_pkg::*;
#(
    parameter int DEADZONE = 40,
    parameter int HYST     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        update,
    input  logic [15:0] sample,
    input  logic [15:0] offset,
    output logic [15:0] corr,
    output logic [1:0]  dir,
    output logic [1:0]  dir_nxt
);

    localparam logic signed [16:0] ENTER_POS = 17'(DEADZONE);
    localparam logic signed [16:0] ENTER_NEG = 17'(-DEADZONE);
    localparam logic signed [16:0] EXIT_POS  = 17'(DEADZONE - HYST);
    localparam logic signed [16:0] EXIT_NEG  = 17'(HYST - DEADZONE);

    logic [16:0]        diff;
    logic [15:0]        corr_nxt;
    logic signed [16:0] corr_s;
    dir_t               dir_q;
    dir_t               dir_d;

    always_comb begin
        diff     = {sample[15], sample} - {offset[15], offset};
        corr_nxt = sat17to16(diff);
        corr_s   = {corr_nxt[15], corr_nxt};
        dir_d    = dir_q;
        if (update) begin
            case (dir_q)
                DIR_NONE: begin
                    if (corr_s > ENTER_POS)      dir_d = DIR_POS;
                    else if (corr_s < ENTER_NEG) dir_d = DIR_NEG;
                end
                // A full swing to the opposite side reverses without passing through none.
                DIR_POS: begin
                    if (corr_s < ENTER_NEG)     dir_d = DIR_NEG;
                    else if (corr_s < EXIT_POS) dir_d = DIR_NONE;
                end
                DIR_NEG: begin
                    if (corr_s > ENTER_POS)     dir_d = DIR_POS;
                    else if (corr_s > EXIT_NEG) dir_d = DIR_NONE;
                end
                default: dir_d = DIR_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            corr  <= '0;
            dir_q <= DIR_NONE;
        end else if (update) begin
            corr  <= corr_nxt;
            dir_q <= dir_d;
        end
    end

    assign dir     = dir_q;
    assign dir_nxt = dir_d;

endmodule

// File: rtl/tilt_ctrl.sv
// Tilt controller: tear-free sampler, zero-offset calibration, two dead-zoned
// axes and auto-repeating step pulses.
module tilt_ctrl
    import tilt_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int CAL_LOG2   = 4,
    parameter int DEADZONE   = 40,
    parameter int HYST       = 10,
    parameter int REPEAT     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acc_ready,
    input  logic [15:0] acc_x,
    input  logic [15:0] acc_y,
    output logic        calibrated,
    output logic [15:0] x_corr,
    output logic [15:0] y_corr,
    output logic [1:0]  dir_x,
    output logic [1:0]  dir_y,
    output logic        step,
    output logic [3:0]  step_dir
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = 16 + CAL_LOG2;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT + 1) : 1;

    logic          rdy_m;
    logic          rdy_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    smp_t          smp_state;
    logic [31:0]   cap_a;
    logic [31:0]   cap_b;
    logic          sample_ok;
    logic [15:0]   smp_x;
    logic [15:0]   smp_y;

    state_t        state;
    logic [AW-1:0] sum_x;
    logic [AW-1:0] sum_y;
    logic [AW-1:0] sum_x_nxt;
    logic [AW-1:0] sum_y_nxt;
    logic [CAL_LOG2-1:0] cal_cnt;
    logic [15:0]   off_x;
    logic [15:0]   off_y;
    logic [RW-1:0] rep_cnt;

    logic          axis_update;
    logic          axis_clear;
    logic [1:0]    dir_x_nxt;
    logic [1:0]    dir_y_nxt;
    logic [3:0]    vec_new;
    logic [3:0]    vec_old;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= acc_ready;
            rdy_s <= rdy_m;
        end
    end

    assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TW'(1);
    end

    // Double capture: a sample is only trusted once two consecutive clk reads agree.
    // Ticks that land while a capture is still resolving are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            smp_state <= SMP_IDLE;
            cap_a     <= '0;
            cap_b     <= '0;
        end else begin
            case (smp_state)
                SMP_IDLE: begin
                    if (tick) begin
                        cap_a     <= {acc_x, acc_y};
                        smp_state <= SMP_CAPB;
                    end
                end
                SMP_CAPB: begin
                    cap_b     <= {acc_x, acc_y};
                    smp_state <= SMP_CMP;
                end
                SMP_CMP: begin
                    if (cap_a == cap_b) begin
                        smp_state <= SMP_IDLE;
                    end else begin
                        cap_a <= cap_b;
                        cap_b <= {acc_x, acc_y};
                    end
                end
                default: smp_state <= SMP_IDLE;
            endcase
        end
    end

    assign sample_ok = (smp_state == SMP_CMP) && (cap_a == cap_b);
    assign smp_x     = cap_b[31:16];
    assign smp_y     = cap_b[15:0];

    assign sum_x_nxt   = sum_x + {{CAL_LOG2{smp_x[15]}}, smp_x};
    assign sum_y_nxt   = sum_y + {{CAL_LOG2{smp_y[15]}}, smp_y};
    assign axis_update = sample_ok && (state == RUN) && rdy_s;
    assign axis_clear  = (state == RUN) && !rdy_s;
    assign vec_new     = {dir_y_nxt, dir_x_nxt};
    assign vec_old     = {dir_y, dir_x};

    tilt_axis #(
        .DEADZONE (DEADZONE),
        .HYST     (HYST)
    ) u_axis_x (
        .clk     (clk),
        .reset   (reset),
        .clear   (axis_clear),
        .update  (axis_update),
        .sample  (smp_x),
        .offset  (off_x),
        .corr    (x_corr),
        .dir     (dir_x),
        .dir_nxt (dir_x_nxt)
    );

    tilt_axis #(
        .DEADZONE (DEADZONE),
        .HYST     (HYST)
    ) u_axis_y (
        .clk     (clk),
        .reset   (reset),
        .clear   (axis_clear),
        .update  (axis_update),
        .sample  (smp_y),
        .offset  (off_y),
        .corr    (y_corr),
        .dir     (dir_y),
        .dir_nxt (dir_y_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_READY;
            sum_x      <= '0;
            sum_y      <= '0;
            cal_cnt    <= '0;
            off_x      <= '0;
            off_y      <= '0;
            calibrated <= 1'b0;
            step       <= 1'b0;
            step_dir   <= '0;
            rep_cnt    <= '0;
        end else begin
            step <= 1'b0;
            case (state)
                WAIT_READY: begin
                    if (rdy_s) begin
                        sum_x   <= '0;
                        sum_y   <= '0;
                        cal_cnt <= '0;
                        state   <= CAL;
                    end
                end
                CAL: begin
                    if (!rdy_s) begin
                        state <= WAIT_READY;
                    end else if (sample_ok) begin
                        sum_x   <= sum_x_nxt;
                        sum_y   <= sum_y_nxt;
                        cal_cnt <= cal_cnt + CAL_LOG2'(1);
                        if (cal_cnt == '1) begin
                            // The mean of 16-bit samples always fits 16 bits, so the
                            // arithmetic shift reduces to a bit slice.
                            off_x      <= sum_x_nxt[CAL_LOG2 +: 16];
                            off_y      <= sum_y_nxt[CAL_LOG2 +: 16];
                            calibrated <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!rdy_s) begin
                        calibrated <= 1'b0;
                        step_dir   <= '0;
                        rep_cnt    <= '0;
                        state      <= WAIT_READY;
                    end else if (sample_ok) begin
                        if (vec_new != '0) begin
                            if (vec_new != vec_old || rep_cnt == RW'(REPEAT - 1)) begin
                                step     <= 1'b1;
                                step_dir <= vec_new;
                                rep_cnt  <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + RW'(1);
                            end
                        end else begin
                            rep_cnt <= '0;
                        end
                    end
                end
                default: state <= WAIT_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_tilt_ctrl.sv
// Randomized and directed bench for tilt_ctrl against a per-clock behavioural model.
module tb_tilt_ctrl;

    localparam int SDIV = 4;
    localparam int CL   = 4;
    localparam int DZ   = 40;
    localparam int HY   = 10;
    localparam int RP   = 8;
    localparam int MW   = 0;
    localparam int MC   = 1;
    localparam int MR   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        acc_ready = 1'b0;
    logic [15:0] acc_x = '0;
    logic [15:0] acc_y = '0;
    logic        calibrated;
    logic [15:0] x_corr;
    logic [15:0] y_corr;
    logic [1:0]  dir_x;
    logic [1:0]  dir_y;
    logic        step;
    logic [3:0]  step_dir;

    tilt_ctrl #(
        .SAMPLE_DIV (SDIV),
        .CAL_LOG2   (CL),
        .DEADZONE   (DZ),
        .HYST       (HY),
        .REPEAT     (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .acc_ready  (acc_ready),
        .acc_x      (acc_x),
        .acc_y      (acc_y),
        .calibrated (calibrated),
        .x_corr     (x_corr),
        .y_corr     (y_corr),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .step       (step),
        .step_dir   (step_dir)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int          m_edge = 0, m_tcnt = 0, m_tarm = 0;
    bit          m_armed = 0, m_was_armed = 0, m_ok = 0;
    logic [31:0] m_p1 = '0, m_p2 = '0, m_data = '0, m_last_data = '0;
    int          m_ok_total = 0;
    bit          m_rdy_m = 0, m_rdy_s = 0;
    int          m_mode = MW, m_cnt = 0, m_sx = 0, m_sy = 0, m_offx = 0, m_offy = 0, m_rep = 0;
    bit          e_cal = 0, e_step = 0;
    int          e_xc = 0, e_yc = 0, e_dx = 0, e_dy = 0, e_sd = 0;
    logic signed [15:0] m_xs, m_ys;
    int          m_cx, m_cy, m_ndx, m_ndy, m_ov, m_nv;

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int floor_div(input int s, input int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    // 0 none, 1 positive, 2 negative
    function automatic int next_dir(input int cur, input int c);
        if (c > DZ && cur != 1) return 1;
        if (c < -DZ && cur != 2) return 2;
        if (cur == 1 && c < DZ - HY) return 0;
        if (cur == 2 && c > -(DZ - HY)) return 0;
        return cur;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_tcnt = 0; m_armed = 0; m_mode = MW; m_rdy_m = 0; m_rdy_s = 0;
            m_sx = 0; m_sy = 0; m_cnt = 0; m_offx = 0; m_offy = 0; m_rep = 0;
            e_cal = 0; e_xc = 0; e_yc = 0; e_dx = 0; e_dy = 0; e_step = 0; e_sd = 0;
        end else begin
            m_edge++;
            m_was_armed = m_armed;
            m_ok = 0;
            // accepted at the first pair of equal consecutive reads after the tick
            if (m_armed && m_edge >= m_tarm + 2 && m_p1 == m_p2) begin
                m_ok = 1; m_armed = 0; m_data = m_p1;
                m_ok_total++; m_last_data = m_p1;
            end
            if (m_tcnt == SDIV - 1) begin
                m_tcnt = 0;
                if (!m_was_armed) begin m_armed = 1; m_tarm = m_edge; end
            end else begin
                m_tcnt++;
            end
            m_p2 = m_p1;
            m_p1 = {acc_x, acc_y};
            m_xs = m_data[31:16];
            m_ys = m_data[15:0];
            e_step = 0;
            case (m_mode)
                MW: if (m_rdy_s) begin m_sx = 0; m_sy = 0; m_cnt = 0; m_mode = MC; end
                MC: begin
                    if (!m_rdy_s) m_mode = MW;
                    else if (m_ok) begin
                        m_sx += int'(m_xs); m_sy += int'(m_ys); m_cnt++;
                        if (m_cnt == (1 << CL)) begin
                            m_offx = floor_div(m_sx, 1 << CL);
                            m_offy = floor_div(m_sy, 1 << CL);
                            m_mode = MR; e_cal = 1;
                        end
                    end
                end
                default: begin
                    if (!m_rdy_s) begin
                        e_cal = 0; e_xc = 0; e_yc = 0; e_dx = 0; e_dy = 0; m_mode = MW;
                    end else if (m_ok) begin
                        m_cx = clamp16(int'(m_xs) - m_offx);
                        m_cy = clamp16(int'(m_ys) - m_offy);
                        m_ndx = next_dir(e_dx, m_cx);
                        m_ndy = next_dir(e_dy, m_cy);
                        m_ov = e_dy * 4 + e_dx;
                        m_nv = m_ndy * 4 + m_ndx;
                        if (m_nv == 0) m_rep = 0;
                        else if (m_nv != m_ov) begin e_step = 1; e_sd = m_nv; m_rep = 0; end
                        else begin
                            m_rep++;
                            if (m_rep == RP) begin e_step = 1; e_sd = m_nv; m_rep = 0; end
                        end
                        e_xc = m_cx; e_yc = m_cy; e_dx = m_ndx; e_dy = m_ndy;
                    end
                end
            endcase
            m_rdy_s = m_rdy_m;
            m_rdy_m = acc_ready;
        end
    end

    // ---------------- compare process ----------------
    bit         chk_en = 0;
    bit         prev_step = 0;
    int         step_count = 0;
    logic [3:0] last_sd = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("calibrated", int'(calibrated), int'(e_cal));
            check("x_corr", int'($signed(x_corr)), e_xc);
            check("y_corr", int'($signed(y_corr)), e_yc);
            check("dir_x", int'(dir_x), e_dx);
            check("dir_y", int'(dir_y), e_dy);
            check("step", int'(step), int'(e_step));
            if (e_step) check("step_dir", int'(step_dir), e_sd);
            if (step) begin
                step_count++;
                last_sd = step_dir;
                check("step_width", int'(prev_step), 0);
            end
            prev_step = step;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic hold_val(input int x, input int y, input int n);
        int got;
        int seen;
        int budget;
        got = 0;
        seen = m_ok_total;
        budget = n * SDIV * 8 + 40;
        acc_x = 16'(x);
        acc_y = 16'(y);
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (m_ok_total != seen) begin
                seen = m_ok_total;
                if (m_last_data == {16'(x), 16'(y)}) got++;
            end
        end
        if (got < n) check("hold_timeout", got, n);
        @(negedge clk);
    endtask

    task automatic wait_mode(input int md, input int budget);
        int b;
        b = budget;
        while (m_mode != md && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("wait_mode", m_mode, md);
        @(negedge clk);
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    int sc0;

    initial begin
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_calibrated", int'(calibrated), 0);
        check("rst_x_corr", int'(x_corr), 0);
        check("rst_dir", int'({dir_y, dir_x}), 0);
        check("rst_step", int'(step), 0);
        reset = 0;

        // calibration with constant inputs
        acc_x = 16'(100); acc_y = 16'(-7); acc_ready = 1;
        wait_mode(MR, 400);
        check("model_offx", m_offx, 100);
        check("model_offy", m_offy, -7);
        hold_val(100, -7, 2);
        check("cal_flag", int'(calibrated), 1);
        check("cal_x_corr", int'($signed(x_corr)), 0);
        check("cal_y_corr", int'($signed(y_corr)), 0);
        check("cal_dir", int'({dir_y, dir_x}), 0);
        check("cal_no_step", step_count, 0);

        // dead zone and hysteresis on x
        hold_val(140, -7, 2);
        check("dz_edge_dir", int'(dir_x), 0);
        check("dz_edge_corr", int'($signed(x_corr)), 40);
        sc0 = step_count;
        hold_val(141, -7, 1);
        check("dz_enter_dir", int'(dir_x), 1);
        check("dz_enter_step", step_count - sc0, 1);
        check("dz_enter_sd", int'(last_sd), 1);
        hold_val(131, -7, 2);
        check("hyst_hold", int'(dir_x), 1);
        hold_val(129, -7, 1);
        check("hyst_exit", int'(dir_x), 0);

        // auto-repeat: entry plus every 8th accepted sample
        sc0 = step_count;
        hold_val(300, -7, 17);
        check("repeat_steps", step_count - sc0, 3);

        // ready loss while active
        acc_ready = 0;
        repeat (3) @(negedge clk);
        check("loss_cal", int'(calibrated), 0);
        check("loss_dir", int'({dir_y, dir_x}), 0);
        check("loss_corr", int'(x_corr), 0);

        // recalibration at -100, then saturation and reversal
        acc_x = 16'(-100); acc_y = 16'(0); acc_ready = 1;
        wait_mode(MR, 400);
        check("model_offx2", m_offx, -100);
        hold_val(32767, 0, 1);
        check("sat_corr", int'($signed(x_corr)), 32767);
        check("sat_dir", int'(dir_x), 1);
        sc0 = step_count;
        hold_val(-32768, 0, 1);
        check("rev_corr", int'($signed(x_corr)), -32668);
        check("rev_dir", int'(dir_x), 2);
        check("rev_step", step_count - sc0, 1);
        check("rev_sd", int'(last_sd), 2);

        // torn reads are never accepted
        hold_val(7, 0, 1);
        for (int i = 0; i < 24; i++) begin
            acc_x = (i % 2 == 0) ? 16'd5 : 16'd6;
            @(negedge clk);
        end
        check("tear_reject", int'($signed(x_corr)), 107);
        hold_val(6, 0, 1);
        check("tear_accept", int'($signed(x_corr)), 106);

        // randomized operation
        for (int it = 0; it < 500; it++) begin
            int r;
            int v;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                acc_ready = 0;
                repeat ($urandom_range(2, 6)) @(negedge clk);
                acc_ready = 1;
            end else if (r < 5) begin
                reset = 1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 0;
            end else if (r < 20) begin
                repeat ($urandom_range(1, 8)) begin
                    acc_x = 16'($urandom);
                    acc_y = 16'($urandom);
                    @(negedge clk);
                end
            end else begin
                v = int'($urandom_range(0, 200)) - 100;
                acc_x = 16'(v);
                v = int'($urandom_range(0, 200)) - 100;
                acc_y = 16'(v);
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end

        // reset in the middle of calibration
        acc_ready = 0;
        repeat (4) @(negedge clk);
        acc_x = 16'(20); acc_y = 16'(-20); acc_ready = 1;
        wait_mode(MC, 100);
        repeat (20) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("midcal_rst_cal", int'(calibrated), 0);
        check("midcal_rst_out", int'({x_corr, y_corr, dir_y, dir_x, step}), 0);
        check("midcal_rst_mode", m_mode, MW);
        reset = 0;
        wait_mode(MR, 500);
        check("midcal_recal", int'(calibrated), 1);

        repeat (4) @(negedge clk);
        finish_run();
    end

    initial begin
        #800000;
        check("watchdog", 0, 1);
        finish_run();
    end

endmodule
